// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
//   Shared constants for the registered 8-bit ALU:
//   - default data width and operation count
//   - control FSM state encoding
//   - bit positions inside the one-hot operation select (out_sel)
//   - bit positions inside the operand-register control (in_sel)
// ---------------------------------------------------------------------------
package alu_pkg;

  localparam int ALU_W    = 8;
  localparam int ALU_NOPS = 7;

  // Control FSM encoding; the values are visible on currState/nextState.
  typedef enum logic [1:0] {
    OFF   = 2'b00,
    READY = 2'b01,
    RUN   = 2'b10,
    ERR   = 2'b11
  } state_e;

  // out_sel bit positions, one operation per bit.
  localparam int OP_ADD = 6;
  localparam int OP_SUB = 5;
  localparam int OP_MUL = 4;
  localparam int OP_AND = 3;
  localparam int OP_OR  = 2;
  localparam int OP_XOR = 1;
  localparam int OP_NOT = 0;

  // in_sel bit positions.
  localparam int SEL_CLEAR   = 0;
  localparam int SEL_LOAD    = 1;
  localparam int SEL_PERSIST = 2;

endpackage

// File: rtl/alu_core.sv
// ---------------------------------------------------------------------------
// alu_core
//   Purely combinational datapath: result = op(a, b).
//   All results are unsigned, truncated to W bits, no flags.
//   Any op that is not exactly one of the known one-hot codes yields 0, so
//   an invalid select seen by the result register clears it.
// Ports:
//   a_i      [W-1:0]     operand A
//   b_i      [W-1:0]     operand B
//   op_i     [NOPS-1:0]  one-hot operation select
//   result_o [W-1:0]     operation result
// ---------------------------------------------------------------------------
module alu_core
  import alu_pkg::*;
#(
  parameter int W    = ALU_W,
  parameter int NOPS = ALU_NOPS
) (
  input  logic [W-1:0]    a_i,
  input  logic [W-1:0]    b_i,
  input  logic [NOPS-1:0] op_i,
  output logic [W-1:0]    result_o
);

  logic [2*W-1:0] prod_s;

  // Full-width product; only the low W bits are used.
  assign prod_s = {{W{1'b0}}, a_i} * {{W{1'b0}}, b_i};

  // Select the operation result from the one-hot code.
  always_comb begin
    result_o = '0;
    case (op_i)
      (NOPS'(1) << OP_ADD): result_o = a_i + b_i;
      (NOPS'(1) << OP_SUB): result_o = a_i - b_i;
      (NOPS'(1) << OP_MUL): result_o = prod_s[W-1:0];
      (NOPS'(1) << OP_AND): result_o = a_i & b_i;
      (NOPS'(1) << OP_OR):  result_o = a_i | b_i;
      (NOPS'(1) << OP_XOR): result_o = a_i ^ b_i;
      (NOPS'(1) << OP_NOT): result_o = ~a_i;
      default:              result_o = '0;
    endcase
  end

endmodule

// File: rtl/main.sv
// ---------------------------------------------------------------------------
// main
//   Registered 8-bit ALU: operand registers, a 2-bit control FSM and a
//   result register fed by the combinational alu_core.
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   on         enable; 0 forces the FSM to OFF and freezes the operands
//   in_sel     [2]=persist, [1]=load, [0]=clear (clear wins over load)
//   num1/num2  operand inputs
//   final1/2   registered operands
//   out_sel    one-hot operation select
//   out        registered ALU result
//   currState  registered FSM state
//   nextState  combinational next FSM state
// ---------------------------------------------------------------------------
module main
  import alu_pkg::*;
#(
  parameter int W    = ALU_W,
  parameter int NOPS = ALU_NOPS
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            on,
  input  logic [2:0]      in_sel,
  input  logic [W-1:0]    num1,
  input  logic [W-1:0]    num2,
  output logic [W-1:0]    final1,
  output logic [W-1:0]    final2,
  input  logic [NOPS-1:0] out_sel,
  output logic [W-1:0]    out,
  output logic [1:0]      currState,
  output logic [1:0]      nextState
);

  logic [W-1:0] final1_q;
  logic [W-1:0] final2_q;
  logic [W-1:0] out_q;
  logic [W-1:0] alu_result_s;
  logic         valid_s;
  state_e       state_q;
  state_e       state_d;

  assign valid_s = $onehot(out_sel);

  alu_core #(
    .W    (W),
    .NOPS (NOPS)
  ) u_core (
    .a_i      (final1_q),
    .b_i      (final2_q),
    .op_i     (out_sel),
    .result_o (alu_result_s)
  );

  // Next-state decode; dropping 'on' always returns to OFF.
  always_comb begin
    state_d = OFF;
    if (!on) begin
      state_d = OFF;
    end else begin
      case (state_q)
        OFF:     state_d = READY;
        READY:   state_d = valid_s ? RUN : ERR;
        RUN:     state_d = valid_s ? RUN : ERR;
        ERR:     state_d = valid_s ? READY : ERR;
        default: state_d = OFF;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= OFF;
    end else begin
      state_q <= state_d;
    end
  end

  // Operand registers; 'on' low freezes them even against clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      final1_q <= '0;
      final2_q <= '0;
    end else if (!on) begin
      final1_q <= final1_q;
      final2_q <= final2_q;
    end else if (in_sel[SEL_CLEAR]) begin
      final1_q <= '0;
      final2_q <= '0;
    end else if (in_sel[SEL_LOAD]) begin
      final1_q <= num1;
      final2_q <= num2;
    end else if (in_sel[SEL_PERSIST]) begin
      final1_q <= final1_q;
      final2_q <= final2_q;
    end else begin
      final1_q <= final1_q;
      final2_q <= final2_q;
    end
  end

  // Result register; computes from the operand values held before this edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= '0;
    end else begin
      case (state_q)
        RUN:     out_q <= alu_result_s;
        READY:   out_q <= out_q;
        OFF:     out_q <= '0;
        ERR:     out_q <= '0;
        default: out_q <= '0;
      endcase
    end
  end

  assign final1    = final1_q;
  assign final2    = final2_q;
  assign out       = out_q;
  assign currState = state_q;
  assign nextState = state_d;

endmodule

// File: tb/tb_main.sv
// ---------------------------------------------------------------------------
// tb_main
//   Directed table-driven bench for main, plus a hand-written reset-mid-RUN
//   sequence. Inputs change 1 time unit after a rising edge; outputs are
//   sampled 1 time unit after the following rising edge.
// ---------------------------------------------------------------------------
module tb_main;

  localparam logic [6:0] ADD = 7'b1000000;
  localparam logic [6:0] SUB = 7'b0100000;
  localparam logic [6:0] MUL = 7'b0010000;
  localparam logic [6:0] AND = 7'b0001000;
  localparam logic [6:0] OR_ = 7'b0000100;
  localparam logic [6:0] XOR = 7'b0000010;
  localparam logic [6:0] NOT = 7'b0000001;
  localparam logic [6:0] BAD = 7'b0000011;

  localparam int NV = 26;

  typedef struct {
    logic       rst;
    logic       on;
    logic [2:0] in_sel;
    logic [7:0] num1;
    logic [7:0] num2;
    logic [6:0] out_sel;
    logic [7:0] e_f1;
    logic [7:0] e_f2;
    logic [7:0] e_out;
    logic [1:0] e_st;
    logic [1:0] e_nx;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       on;
  logic [2:0] in_sel;
  logic [7:0] num1;
  logic [7:0] num2;
  logic [7:0] final1;
  logic [7:0] final2;
  logic [6:0] out_sel;
  logic [7:0] out;
  logic [1:0] currState;
  logic [1:0] nextState;

  int   passed = 0;
  int   total  = 0;
  vec_t vecs[NV];

  main dut (
    .clk       (clk),
    .rst       (rst),
    .on        (on),
    .in_sel    (in_sel),
    .num1      (num1),
    .num2      (num2),
    .final1    (final1),
    .final2    (final2),
    .out_sel   (out_sel),
    .out       (out),
    .currState (currState),
    .nextState (nextState)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int idx,
                       input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act === exp) begin
      passed++;
    end else begin
      $display("FAIL %s[%0d] got %02h want %02h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic o, input logic [2:0] s,
                       input logic [7:0] a, input logic [7:0] b,
                       input logic [6:0] op);
    rst     = r;
    on      = o;
    in_sel  = s;
    num1    = a;
    num2    = b;
    out_sel = op;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input int idx,
                           input logic [7:0] f1, input logic [7:0] f2,
                           input logic [7:0] o, input logic [1:0] st);
    check({tag, "_final1"}, idx, final1, f1);
    check({tag, "_final2"}, idx, final2, f2);
    check({tag, "_out"}, idx, out, o);
    check({tag, "_state"}, idx, {6'd0, currState}, {6'd0, st});
  endtask

  initial begin
    // rst on in_sel num1 num2 out_sel | final1 final2 out state next
    vecs[0]  = '{1'b1, 1'b0, 3'b000, 8'h00, 8'h00, 7'b0000000, 8'h00, 8'h00, 8'h00, 2'b00, 2'b00};
    vecs[1]  = '{1'b1, 1'b1, 3'b010, 8'h33, 8'h44, ADD, 8'h00, 8'h00, 8'h00, 2'b00, 2'b01};
    vecs[2]  = '{1'b0, 1'b1, 3'b010, 8'h57, 8'h1A, ADD, 8'h57, 8'h1A, 8'h00, 2'b01, 2'b10};
    vecs[3]  = '{1'b0, 1'b1, 3'b100, 8'h57, 8'h1A, ADD, 8'h57, 8'h1A, 8'h00, 2'b10, 2'b10};
    vecs[4]  = '{1'b0, 1'b1, 3'b100, 8'h57, 8'h1A, ADD, 8'h57, 8'h1A, 8'h71, 2'b10, 2'b10};
    vecs[5]  = '{1'b0, 1'b1, 3'b000, 8'h00, 8'h00, SUB, 8'h57, 8'h1A, 8'h3D, 2'b10, 2'b10};
    vecs[6]  = '{1'b0, 1'b1, 3'b000, 8'h00, 8'h00, MUL, 8'h57, 8'h1A, 8'hD6, 2'b10, 2'b10};
    vecs[7]  = '{1'b0, 1'b1, 3'b000, 8'h00, 8'h00, AND, 8'h57, 8'h1A, 8'h12, 2'b10, 2'b10};
    vecs[8]  = '{1'b0, 1'b1, 3'b000, 8'h00, 8'h00, OR_, 8'h57, 8'h1A, 8'h5F, 2'b10, 2'b10};
    vecs[9]  = '{1'b0, 1'b1, 3'b000, 8'h00, 8'h00, XOR, 8'h57, 8'h1A, 8'h4D, 2'b10, 2'b10};
    vecs[10] = '{1'b0, 1'b1, 3'b000, 8'h00, 8'h00, NOT, 8'h57, 8'h1A, 8'hA8, 2'b10, 2'b10};
    vecs[11] = '{1'b0, 1'b1, 3'b000, 8'h00, 8'h00, BAD, 8'h57, 8'h1A, 8'h00, 2'b11, 2'b11};
    vecs[12] = '{1'b0, 1'b1, 3'b000, 8'h00, 8'h00, NOT, 8'h57, 8'h1A, 8'h00, 2'b01, 2'b10};
    vecs[13] = '{1'b0, 1'b1, 3'b000, 8'h00, 8'h00, NOT, 8'h57, 8'h1A, 8'h00, 2'b10, 2'b10};
    vecs[14] = '{1'b0, 1'b1, 3'b000, 8'h00, 8'h00, NOT, 8'h57, 8'h1A, 8'hA8, 2'b10, 2'b10};
    vecs[15] = '{1'b0, 1'b1, 3'b010, 8'hFF, 8'h01, ADD, 8'hFF, 8'h01, 8'h71, 2'b10, 2'b10};
    vecs[16] = '{1'b0, 1'b1, 3'b000, 8'hFF, 8'h01, ADD, 8'hFF, 8'h01, 8'h00, 2'b10, 2'b10};
    vecs[17] = '{1'b0, 1'b1, 3'b010, 8'h00, 8'h01, SUB, 8'h00, 8'h01, 8'hFE, 2'b10, 2'b10};
    vecs[18] = '{1'b0, 1'b1, 3'b000, 8'h00, 8'h01, SUB, 8'h00, 8'h01, 8'hFF, 2'b10, 2'b10};
    vecs[19] = '{1'b0, 1'b1, 3'b010, 8'h10, 8'h10, MUL, 8'h10, 8'h10, 8'h00, 2'b10, 2'b10};
    vecs[20] = '{1'b0, 1'b1, 3'b000, 8'h10, 8'h10, MUL, 8'h10, 8'h10, 8'h00, 2'b10, 2'b10};
    vecs[21] = '{1'b0, 1'b1, 3'b000, 8'h10, 8'h10, ADD, 8'h10, 8'h10, 8'h20, 2'b10, 2'b10};
    vecs[22] = '{1'b0, 1'b0, 3'b010, 8'hAA, 8'hBB, ADD, 8'h10, 8'h10, 8'h20, 2'b00, 2'b00};
    vecs[23] = '{1'b0, 1'b0, 3'b001, 8'hAA, 8'hBB, ADD, 8'h10, 8'h10, 8'h00, 2'b00, 2'b00};
    vecs[24] = '{1'b0, 1'b1, 3'b001, 8'hAA, 8'hBB, ADD, 8'h00, 8'h00, 8'h00, 2'b01, 2'b10};
    vecs[25] = '{1'b0, 1'b1, 3'b011, 8'hAA, 8'hBB, ADD, 8'h00, 8'h00, 8'h00, 2'b10, 2'b10};

    drive(1'b1, 1'b0, 3'b000, 8'h00, 8'h00, 7'b0000000);

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].rst, vecs[i].on, vecs[i].in_sel, vecs[i].num1,
            vecs[i].num2, vecs[i].out_sel);
      step();
      check_all("vec", i, vecs[i].e_f1, vecs[i].e_f2, vecs[i].e_out, vecs[i].e_st);
      check("vec_next", i, {6'd0, nextState}, {6'd0, vecs[i].e_nx});
    end

    // Reset in the middle of RUN with a nonzero result, then restart.
    drive(1'b0, 1'b1, 3'b010, 8'h57, 8'h1A, ADD);
    step();
    step();
    check_all("pre_rst", 0, 8'h57, 8'h1A, 8'h71, 2'b10);

    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b1, 3'b010, 8'h02, 8'h04, ADD);
      step();
      check_all("in_rst", k, 8'h00, 8'h00, 8'h00, 2'b00);
    end

    drive(1'b0, 1'b1, 3'b010, 8'h02, 8'h04, ADD);
    step();
    check_all("rel1", 0, 8'h02, 8'h04, 8'h00, 2'b01);
    step();
    check_all("rel2", 0, 8'h02, 8'h04, 8'h00, 2'b10);
    step();
    check_all("rel3", 0, 8'h02, 8'h04, 8'h06, 2'b10);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
